// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a master and the apb_slave_mem register file.
interface apb_slave_mem_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB slave exposing DEPTH 32-bit registers with a fixed number of wait states
// and registered PREADY/PSLVERR/PRDATA.
module apb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_slave_mem_if.slave    bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               write_q;
    logic [31:0]        mem [DEPTH];

    logic               setup_c;
    logic               accept_c;
    logic [31:0]        addr_n;
    logic               write_n;
    logic [29:0]        word_off;
    logic [IDX_W-1:0]   idx;
    logic               err_c;
    logic               we_c;
    logic               ready_d;
    logic               slverr_d;
    logic [31:0]        rdata_d;

    assign setup_c  = bus.PSEL & ~bus.PENABLE;
    assign accept_c = (state == S_IDLE) & setup_c;

    // Decode the address the transfer will use: live bus on the setup edge, latched copy afterwards.
    assign addr_n   = accept_c ? bus.PADDR  : addr_q;
    assign write_n  = accept_c ? bus.PWRITE : write_q;
    assign word_off = 30'((addr_n - BASE_ADDR) >> 2);
    assign idx      = word_off[IDX_W-1:0];
    assign err_c    = (addr_n < BASE_ADDR) | (word_off >= 30'(DEPTH)) | (addr_n[1:0] != 2'b00);

    assign we_c = (state == S_READY) & bus.PSEL & bus.PENABLE & write_q & ~err_c;

    // State register, transfer latch and registered outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            bus.PREADY  <= 1'b0;
            bus.PSLVERR <= 1'b0;
            bus.PRDATA  <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            bus.PREADY  <= ready_d;
            bus.PSLVERR <= slverr_d;
            bus.PRDATA  <= rdata_d;
            if (accept_c) begin
                addr_q  <= bus.PADDR;
                wdata_q <= bus.PWDATA;
                write_q <= bus.PWRITE;
            end
        end
    end

    // Next-state logic; dropping PSEL mid-transfer abandons it.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (setup_c) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_READY;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!bus.PSEL) begin
                    state_d = S_IDLE;
                end else if (cnt == '0) begin
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_READY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle; only the READY cycle carries data or error.
    always_comb begin
        ready_d  = (state_d == S_READY);
        slverr_d = ready_d & err_c;
        rdata_d  = '0;
        if (ready_d && !write_n && !err_c) begin
            rdata_d = mem[idx];
        end
    end

    // Register file; writes commit on the edge that ends the READY cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we_c) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: default, zero-wait and offset-base instances.
module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel   [3];
    logic        en    [3];
    logic        wr    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic        err   [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_slave_mem_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_bus
        assign bus[g].PSEL    = sel[g];
        assign bus[g].PENABLE = en[g];
        assign bus[g].PWRITE  = wr[g];
        assign bus[g].PADDR   = addr[g];
        assign bus[g].PWDATA  = wdata[g];
        assign rdata[g]       = bus[g].PRDATA;
        assign rdy[g]         = bus[g].PREADY;
        assign err[g]         = bus[g].PSLVERR;
    end

    apb_slave_mem u_def (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus[0])
    );

    apb_slave_mem #(.WAIT_CYCLES(0)) u_w0 (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus[1])
    );

    apb_slave_mem #(.BASE_ADDR(32'h0000_0100)) u_base (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Full transfer; returns while the READY cycle is still in progress.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                        input string tag);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        sel[d] = 1'b1; en[d] = 1'b0; wr[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1;
        en[d] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rdy[d]) begin
                lat = k;
                break;
            end
            addr[d]  = 32'hFFFF_FFF0;
            wdata[d] = ~wd;
            wr[d]    = ~w;
        end
        check({tag, "_lat"},   32'(lat),    32'(exp_lat));
        check({tag, "_err"},   32'(err[d]), 32'(exp_err));
        check({tag, "_rdata"}, rdata[d],    exp_rd);
    endtask

    task automatic idle(input int d, input string tag);
        @(posedge clk); #1;
        sel[d] = 1'b0; en[d] = 1'b0;
        @(negedge clk);
        check({tag, "_idle_rdy"},   32'(rdy[d]), 32'd0);
        check({tag, "_idle_err"},   32'(err[d]), 32'd0);
        check({tag, "_idle_rdata"}, rdata[d],    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel[i] = 1'b0; en[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy",   32'(rdy[0]), 32'd0);
        check("rst_err",   32'(err[0]), 32'd0);
        check("rst_rdata", rdata[0],    32'd0);
        rst_n = 1'b1;

        // Default instance: basic write/read, three access cycles to PREADY.
        xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 3, 32'h0, 1'b0, "wr08");
        idle(0, "wr08");
        xfer(0, 1'b0, 32'h08, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, "rd08");
        idle(0, "rd08");

        // Decode errors, including no wrap from the top of the address space.
        xfer(0, 1'b0, 32'h40, 32'h0, 3, 32'h0, 1'b1, "rd40");
        idle(0, "rd40");
        xfer(0, 1'b0, 32'h05, 32'h0, 3, 32'h0, 1'b1, "rd05");
        idle(0, "rd05");
        xfer(0, 1'b1, 32'h40, 32'h77, 3, 32'h0, 1'b1, "wr40");
        idle(0, "wr40");
        xfer(0, 1'b1, 32'hFFFF_FFFC, 32'h99, 3, 32'h0, 1'b1, "wrtop");
        idle(0, "wrtop");
        xfer(0, 1'b0, 32'h00, 32'h0, 3, 32'h0, 1'b0, "rd00");
        idle(0, "rd00");

        // PENABLE without a setup phase must not start a transfer.
        @(posedge clk); #1;
        sel[0] = 1'b1; en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h5A5A;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("noset_rdy", 32'(rdy[0]), 32'd0);
        end
        idle(0, "noset");
        xfer(0, 1'b0, 32'h10, 32'h0, 3, 32'h0, 1'b0, "rd10");
        idle(0, "rd10");

        // Abort by dropping PSEL in the first access cycle.
        @(posedge clk); #1;
        sel[0] = 1'b1; en[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h0C; wdata[0] = 32'h1234;
        @(posedge clk); #1;
        sel[0] = 1'b0; en[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_rdy", 32'(rdy[0]), 32'd0);
        end
        xfer(0, 1'b0, 32'h0C, 32'h0, 3, 32'h0, 1'b0, "rd0c");
        idle(0, "rd0c");

        // Asynchronous reset during a READY cycle clears outputs at once.
        xfer(0, 1'b0, 32'h08, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, "rd08b");
        #1 rst_n = 1'b0;
        #1;
        check("rstrdy_rdy",   32'(rdy[0]), 32'd0);
        check("rstrdy_rdata", rdata[0],    32'd0);
        sel[0] = 1'b0; en[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-WAIT aborts the write.
        @(posedge clk); #1;
        sel[0] = 1'b1; en[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h3C; wdata[0] = 32'hAAAA;
        @(posedge clk); #1;
        en[0] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rstwait_rdy",   32'(rdy[0]), 32'd0);
        check("rstwait_err",   32'(err[0]), 32'd0);
        check("rstwait_rdata", rdata[0],    32'd0);
        sel[0] = 1'b0; en[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 1'b0, 32'h3C, 32'h0, 3, 32'h0, 1'b0, "rd3c");
        idle(0, "rd3c");
        xfer(0, 1'b0, 32'h08, 32'h0, 3, 32'h0, 1'b0, "rd08c");
        idle(0, "rd08c");

        // Zero-wait instance: back-to-back transfers with no idle cycle.
        xfer(1, 1'b1, 32'h00, 32'h11, 1, 32'h0, 1'b0, "w0_wr00");
        xfer(1, 1'b1, 32'h04, 32'h22, 1, 32'h0, 1'b0, "w0_wr04");
        xfer(1, 1'b0, 32'h00, 32'h0, 1, 32'h11, 1'b0, "w0_rd00");
        xfer(1, 1'b0, 32'h04, 32'h0, 1, 32'h22, 1'b0, "w0_rd04");
        idle(1, "w0");

        // Offset-base instance.
        xfer(2, 1'b1, 32'h104, 32'h55, 3, 32'h0, 1'b0, "b_wr104");
        idle(2, "b_wr104");
        xfer(2, 1'b0, 32'h104, 32'h0, 3, 32'h55, 1'b0, "b_rd104");
        idle(2, "b_rd104");
        xfer(2, 1'b0, 32'h100, 32'h0, 3, 32'h0, 1'b0, "b_rd100");
        idle(2, "b_rd100");
        xfer(2, 1'b0, 32'h0FC, 32'h0, 3, 32'h0, 1'b1, "b_rd0fc");
        idle(2, "b_rd0fc");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 16, number of 32-bit registers (power of 2, 2..256).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, access-phase wait states before PREADY (0..15).
REQ-004 SHALL have port PCLK  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port PRESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port PSEL  input  1  slave select from APB master.
REQ-007 SHALL have port PENABLE  input  1  access-phase indicator.
REQ-008 SHALL have port PWRITE  input  1  1 = write, 0 = read.
REQ-009 SHALL have port PADDR  input  32  byte address.
REQ-010 SHALL have port PWDATA  input  32  write data.
REQ-011 SHALL have port PRDATA  output  32  read data, registered.
REQ-012 SHALL have port PREADY  output  1  transfer-complete strobe, registered.
REQ-013 SHALL have port PSLVERR  output  1  error response, registered, valid only when PREADY=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, READY.
REQ-015 IDLE: on PSEL=1 & PENABLE=0 (setup), SHALL latch PADDR, PWRITE, PWDATA; WAIT_CYCLES=0 -> READY, else -> WAIT with counter = WAIT_CYCLES-1.
REQ-016 WAIT: PREADY=0; counter decrements each cycle; at counter=0 -> READY.
REQ-017 READY: PREADY=1 for exactly one cycle, then -> IDLE; PREADY SHALL never be high two consecutive cycles for one transfer.
REQ-018 Latency: PREADY high in access-phase cycle WAIT_CYCLES+1 (first access cycle = cycle after setup).
REQ-019 Decode: index = (addr - BASE_ADDR) >> 2; error if addr < BASE_ADDR, index >= DEPTH, or addr[1:0] != 0.
REQ-020 Valid write: register[index] <= latched PWDATA on the edge ending the READY cycle, only if PSEL=1 & PENABLE=1 in that cycle.
REQ-021 Valid read: PRDATA = register[index] during the READY cycle; PRDATA = 0 in all other cycles.
REQ-022 Error transfer: PSLVERR=1 and PRDATA=0 during the READY cycle; no register modified; PSLVERR=0 in all other cycles.
REQ-023 Abort: PSEL=0 while in WAIT or READY SHALL return FSM to IDLE next edge, PREADY/PSLVERR low, no write.
REQ-024 Back-to-back: setup in the cycle immediately after READY SHALL be accepted (zero idle cycles required).
REQ-025 PENABLE=1 while in IDLE (no setup seen) SHALL be ignored; no transfer started.
REQ-026 Address arithmetic SHALL be 32-bit unsigned; no wrap-around past 32'hFFFF_FFFC into register 0.
REQ-027 Inputs PADDR/PWRITE/PWDATA changing during WAIT SHALL not affect the transfer in progress.

Reset
REQ-028 PRESETn=0 SHALL immediately (asynchronously) force FSM = IDLE, PREADY=0, PSLVERR=0, PRDATA=0, all registers = 0.
REQ-029 Reset during WAIT/READY SHALL abort the transfer with no register write; first setup after PRESETn rises SHALL be serviced normally.

Verification
REQ-030 Write 0xDEAD_BEEF to 0x08, then read 0x08 (defaults) -> PREADY high in 3rd access cycle each time, PRDATA=0xDEAD_BEEF, PSLVERR=0.
REQ-031 Read 0x40 (index 16) and read 0x05 (misaligned) -> PSLVERR=1, PRDATA=0 in READY cycle; subsequent read of 0x00 returns 0.
REQ-032 WAIT_CYCLES=0: back-to-back writes 0x11 to 0x00, 0x22 to 0x04 with no idle -> PREADY in first access cycle each, readback 0x11, 0x22.
REQ-033 Write 0x1234 to 0x0C with PSEL dropped in 1st access cycle -> no PREADY, read 0x0C returns 0.
REQ-034 Write 0xAAAA to 0x3C, assert PRESETn=0 mid-WAIT -> outputs 0 immediately; after release, read 0x3C returns 0.
REQ-035 BASE_ADDR=0x100: write 0x55 to 0x104 -> OK, read index 1 = 0x55; access 0x0FC -> PSLVERR=1.
